// File: rtl/input_conditioner.sv
// Button/switch front end for the add-shift multiplier: two-flop synchronizers,
// per-key debounce FSMs producing clean active-high levels and one-cycle rise pulses.
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned SW_W            = 8
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Run_btn,
  input  logic            ClrLd_btn,
  input  logic [SW_W-1:0] SW,
  output logic            Run,
  output logic            Run_rise,
  output logic            ClrLd,
  output logic            ClrLd_rise,
  output logic [SW_W-1:0] SW_s
);

  localparam int unsigned NB = 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  logic [NB-1:0]   btn_raw;
  logic [NB-1:0]   btn_sync1;
  logic [NB-1:0]   btn_sync2;
  logic [NB-1:0]   level;
  logic [NB-1:0]   rise;
  logic [SW_W-1:0] sw_sync1;

  assign btn_raw = {ClrLd_btn, Run_btn};

  // Two-flop synchronizers; keys reset to released, switches to zero.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      btn_sync1 <= '1;
      btn_sync2 <= '1;
      sw_sync1  <= '0;
      SW_s      <= '0;
    end else begin
      btn_sync1 <= btn_raw;
      btn_sync2 <= btn_sync1;
      sw_sync1  <= SW;
      SW_s      <= sw_sync1;
    end
  end

  for (genvar i = 0; i < NB; i++) begin : g_btn
    btn_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             level_q;
    logic             rise_q;
    logic             pressed;

    assign pressed = ~btn_sync2[i];
    assign level[i] = level_q;
    assign rise[i]  = rise_q;

    // Debounce FSM: a change is accepted only after DEBOUNCE_CYCLES further
    // consecutive samples agree; any disagreement restarts the wait.
    always_ff @(posedge Clk) begin
      if (!Reset) begin
        state   <= IDLE;
        cnt     <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        case (state)
          IDLE: begin
            if (pressed) begin
              state <= PRESS_WAIT;
              cnt   <= '0;
            end
          end
          PRESS_WAIT: begin
            if (!pressed) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state   <= PRESSED;
              level_q <= 1'b1;
              rise_q  <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          PRESSED: begin
            if (!pressed) begin
              state <= RELEASE_WAIT;
              cnt   <= '0;
            end
          end
          RELEASE_WAIT: begin
            if (pressed) begin
              state <= PRESSED;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state   <= IDLE;
              level_q <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state   <= IDLE;
            cnt     <= '0;
            level_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Run        = level[0];
  assign Run_rise   = rise[0];
  assign ClrLd      = level[1];
  assign ClrLd_rise = rise[1];

endmodule
